// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle, valid/ready in and out.
// Multiply is shift-add on a 2*XLEN accumulator; divide is restoring shift-subtract.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int CW = $clog2(XLEN);

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic            is_div, a_sgn, b_sgn, sa_in, sb_in, div_zero, ovf;
  logic [XLEN-1:0] abs_a, abs_b, quo, rem;
  logic [XLEN:0]   mul_sum, div_diff;
  logic [2*XLEN-1:0] prod;

  assign in_ready  = (state_q == S_IDLE) && !kill;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign result    = result_q;

  always_comb begin
    is_div   = op[2];
    a_sgn    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_sgn    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    sa_in    = a_sgn && A[XLEN-1];
    sb_in    = b_sgn && B[XLEN-1];
    abs_a    = sa_in ? -A : A;
    abs_b    = sb_in ? -B : B;
    div_zero = (B == '0);
    ovf      = ((op == 3'b100) || (op == 3'b110)) &&
               (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
    // Multiply: add multiplicand into the high half when the current multiplier bit is set,
    // then shift right with the carry. Divide: trial-subtract from the shifted partial remainder.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    prod     = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo      = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem      = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          op_d  = op;
          sa_d  = sa_in;
          sb_d  = sb_in;
          cnt_d = CW'(XLEN-1);
          if (is_div && div_zero) begin
            result_d = op[1] ? A : '1;
            state_d  = S_DONE;
          end else if (ovf) begin
            result_d = op[1] ? '0 : A;
            state_d  = S_DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
            opnd_d  = is_div ? abs_b : abs_a;
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          if (!op_q[2])
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          else if (!div_diff[XLEN])
            acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else
            acc_d = {acc_q[2*XLEN-2:0], 1'b0};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = S_FIX;
        end
        S_FIX: begin
          if (!op_q[2])
            result_d = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          else
            result_d = op_q[1] ? rem : quo;
          state_d = S_DONE;
        end
        default: if (out_ready) state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: XLEN=32 and XLEN=16 instances, directed table, corner sequences
// and randomized ops checked against an integer-arithmetic reference model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, kill = 1'b0, out_ready = 1'b0, sel = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] A = '0, B = '0;

  logic        ir32, ov32, bz32, ir16, ov16, bz16;
  logic [31:0] res32;
  logic [15:0] res16;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(ir32), .op(op),
    .A(A), .B(B), .kill(kill), .out_valid(ov32), .out_ready(out_ready),
    .result(res32), .busy(bz32));

  muldiv_unit #(.XLEN(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(ir16), .op(op),
    .A(A[15:0]), .B(B[15:0]), .kill(kill), .out_valid(ov16), .out_ready(out_ready),
    .result(res16), .busy(bz16));

  assign in_ready  = sel ? ir16 : ir32;
  assign out_valid = sel ? ov16 : ov32;
  assign busy      = sel ? bz16 : bz32;
  assign result    = sel ? {16'h0, res16} : res32;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input bit s);
    return s ? 32'h0000FFFF : 32'hFFFFFFFF;
  endfunction

  // Reference: interpret operands as mathematical integers, then apply the RV32M rules.
  function automatic logic [31:0] model(input bit s, input logic [2:0] o,
                                        input logic [31:0] a, input logic [31:0] b);
    int w;
    logic [31:0] m;
    logic signed [127:0] av, bv, p, q, r, mn;
    bit asg, bsg;
    w   = s ? 16 : 32;
    m   = wmask(s);
    asg = (o == 3'd1) || (o == 3'd2) || (o == 3'd4) || (o == 3'd6);
    bsg = (o == 3'd1) || (o == 3'd4) || (o == 3'd6);
    av  = 128'(a & m);
    bv  = 128'(b & m);
    if (asg && a[w-1]) av = av - (128'sd1 <<< w);
    if (bsg && b[w-1]) bv = bv - (128'sd1 <<< w);
    mn  = -(128'sd1 <<< (w-1));
    if (!o[2]) begin
      p = av * bv;
      if (o[1:0] == 2'b00) return 32'(p) & m;
      return 32'(p >>> w) & m;
    end
    if (bv == 0) return o[1] ? (a & m) : m;
    if (asg && av == mn && bv == -128'sd1) return o[1] ? 32'd0 : (a & m);
    q = av / bv;
    r = av % bv;
    return o[1] ? (32'(r) & m) : (32'(q) & m);
  endfunction

  function automatic int exp_lat(input bit s, input logic [2:0] o,
                                 input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m, mn;
    m  = wmask(s);
    mn = s ? 32'h00008000 : 32'h80000000;
    if (o[2] && ((b & m) == 0)) return 1;
    if ((o == 3'd4 || o == 3'd6) && ((a & m) == mn) && ((b & m) == m)) return 1;
    return (s ? 16 : 32) + 2;
  endfunction

  task automatic start_op(input bit s, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    sel = s; op = o; A = a; B = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; op = 3'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input bit s, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output int lat);
    start_op(s, o, a, b);
    wait_valid(lat);
    res = result;
    ack();
  endtask

  task automatic kill_seq(input bit s, input logic [31:0] prev);
    int seen;
    start_op(s, 3'd0, 32'd5, 32'd6);
    @(negedge clk);
    chk("kill_busy_calc1", 64'(busy), 64'd1);
    repeat (4) @(negedge clk);
    kill = 1'b1;
    #1 chk("kill_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    chk("kill_busy", 64'(busy), 64'd0);
    chk("kill_out_valid", 64'(out_valid), 64'd0);
    chk("kill_in_ready", 64'(in_ready), 64'd1);
    chk("kill_result_kept", 64'(result), 64'(prev));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("kill_no_valid", 64'(seen), 64'd0);
  endtask

  function automatic logic [31:0] pick(input bit s);
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return wmask(s);
      2: return s ? 32'h00008000 : 32'h80000000;
      3: return 32'($urandom_range(1, 9));
      default: return $urandom & wmask(s);
    endcase
  endfunction

  typedef struct {
    bit          s;
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[24];
    logic [31:0] res, a, b;
    logic [2:0]  o;
    int lat;

    tbl[0]  = '{0, 3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
    tbl[1]  = '{0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    tbl[2]  = '{0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    tbl[3]  = '{0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[4]  = '{0, 3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    tbl[5]  = '{0, 3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    tbl[6]  = '{0, 3'd5, 32'd100,      32'd7,        32'd14};
    tbl[7]  = '{0, 3'd7, 32'd100,      32'd7,        32'd2};
    tbl[8]  = '{0, 3'd5, 32'd5,        32'd0,        32'hFFFFFFFF};
    tbl[9]  = '{0, 3'd6, 32'd5,        32'd0,        32'd5};
    tbl[10] = '{0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    tbl[11] = '{0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0};
    tbl[12] = '{1, 3'd0, 32'd7,        32'h0000FFFD, 32'h0000FFEB};
    tbl[13] = '{1, 3'd3, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFE};
    tbl[14] = '{1, 3'd1, 32'h00008000, 32'h00008000, 32'h00004000};
    tbl[15] = '{1, 3'd2, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF};
    tbl[16] = '{1, 3'd4, 32'h0000FFF9, 32'd2,        32'h0000FFFD};
    tbl[17] = '{1, 3'd6, 32'h0000FFF9, 32'd2,        32'h0000FFFF};
    tbl[18] = '{1, 3'd5, 32'd100,      32'd7,        32'd14};
    tbl[19] = '{1, 3'd7, 32'd100,      32'd7,        32'd2};
    tbl[20] = '{1, 3'd5, 32'd5,        32'd0,        32'h0000FFFF};
    tbl[21] = '{1, 3'd6, 32'd5,        32'd0,        32'd5};
    tbl[22] = '{1, 3'd4, 32'h00008000, 32'h0000FFFF, 32'h00008000};
    tbl[23] = '{1, 3'd6, 32'h00008000, 32'h0000FFFF, 32'd0};

    #3;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      run_op(tbl[i].s, tbl[i].o, tbl[i].a, tbl[i].b, res, lat);
      chk($sformatf("vec%0d_result", i), 64'(res), 64'(tbl[i].exp));
      chk($sformatf("vec%0d_latency", i), 64'(lat),
          64'(exp_lat(tbl[i].s, tbl[i].o, tbl[i].a, tbl[i].b)));
    end

    // Back-pressure in DONE, then immediate re-accept after the handshake.
    start_op(0, 3'd0, 32'd7, 32'hFFFFFFFD);
    wait_valid(lat);
    chk("hold_latency", 64'(lat), 64'd34);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_result", 64'(result), 64'hFFFFFFEB);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    ack();
    @(negedge clk);
    chk("post_ack_out_valid", 64'(out_valid), 64'd0);
    chk("post_ack_in_ready", 64'(in_ready), 64'd1);
    op = 3'd5; A = 32'd100; B = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; A = 32'd1; B = 32'd1;
    @(negedge clk);
    chk("reaccept_busy", 64'(busy), 64'd1);
    wait_valid(lat);
    chk("reaccept_result", 64'(result), 64'd14);
    ack();

    kill_seq(0, 32'd14);
    run_op(1, 3'd5, 32'd100, 32'd7, res, lat);
    chk("pre_kill16_result", 64'(res), 64'd14);
    kill_seq(1, 32'd14);

    @(negedge clk);
    sel = 1'b0; kill = 1'b1;
    #1 chk("kill_idle_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    kill = 1'b0;

    // Asynchronous reset in the middle of CALC.
    start_op(0, 3'd4, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 60; n++) begin
        o = 3'($urandom_range(0, 7));
        a = pick(s[0]);
        b = pick(s[0]);
        run_op(s[0], o, a, b, res, lat);
        chk($sformatf("rnd_x%0d_op%0d_%0h_%0h", s ? 16 : 32, o, a, b),
            64'(res), 64'(model(s[0], o, a, b)));
        chk("rnd_latency", 64'(lat), 64'(exp_lat(s[0], o, a, b)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
